// File: rtl/sync_capture_fifo_if.sv
// Handshake and status bundle between the capture FIFO and its neighbours.
// master drives the write/read/control requests; slave is the FIFO itself.
interface sync_capture_fifo_if #(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 10
);
  logic                flush;
  logic                wr_en;
  logic [DATA_LEN-1:0] data_in;
  logic                rd_en;
  logic                clr_err;
  logic [DATA_LEN-1:0] data_out;
  logic                data_valid;
  logic                full;
  logic                empty;
  logic                almost_full;
  logic                almost_empty;
  logic [ADDR_LEN:0]   level;
  logic                overflow;
  logic                underflow;

  modport master (
    output flush, wr_en, data_in, rd_en, clr_err,
    input  data_out, data_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, data_in, rd_en, clr_err,
    output data_out, data_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );
endinterface

// File: rtl/sync_capture_fifo.sv
// Single-clock capture FIFO for the logic-analyzer sample path, with FWFT or
// registered read, fill level, almost flags, sticky error flags and flush.
module sync_capture_fifo #(
  parameter int DATA_LEN = 32,
  parameter int DEPTH    = 1024,
  parameter int ADDR_LEN = $clog2(DEPTH),
  parameter bit FWFT     = 1'b1,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input logic               clk,
  input logic               rst,
  sync_capture_fifo_if.slave bus
);
  localparam int                PW      = ADDR_LEN + 1;
  localparam logic [ADDR_LEN:0] PTR_ONE = PW'(1);
  localparam logic [ADDR_LEN:0] AF_LVL  = PW'(AF_LEVEL);
  localparam logic [ADDR_LEN:0] AE_LVL  = PW'(AE_LEVEL);

  logic [DATA_LEN-1:0] mem [DEPTH];
  logic [ADDR_LEN:0]   wr_ptr;
  logic [ADDR_LEN:0]   rd_ptr;
  logic [ADDR_LEN:0]   level;
  logic                full;
  logic                empty;
  logic                wr_acc;
  logic                rd_acc;
  logic                overflow_q;
  logic                underflow_q;

  // Extra pointer MSB separates the full and empty cases when the low bits match.
  assign level  = wr_ptr - rd_ptr;
  assign full   = (wr_ptr[ADDR_LEN] != rd_ptr[ADDR_LEN]) &&
                  (wr_ptr[ADDR_LEN-1:0] == rd_ptr[ADDR_LEN-1:0]);
  assign empty  = (wr_ptr == rd_ptr);
  assign wr_acc = bus.wr_en & ~full & ~bus.flush;
  assign rd_acc = bus.rd_en & ~empty & ~bus.flush;

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[ADDR_LEN-1:0]] <= bus.data_in;
  end

  // A new error event in the same cycle as clr_err leaves the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (!bus.flush) begin
      overflow_q  <= (bus.wr_en & full)  | (overflow_q  & ~bus.clr_err);
      underflow_q <= (bus.rd_en & empty) | (underflow_q & ~bus.clr_err);
    end
  end

  if (FWFT) begin : g_fwft
    assign bus.data_out   = empty ? '0 : mem[rd_ptr[ADDR_LEN-1:0]];
    assign bus.data_valid = ~empty;
  end else begin : g_reg
    logic [DATA_LEN-1:0] dout_q;
    logic                valid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else if (bus.flush) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_acc;
        if (rd_acc) dout_q <= mem[rd_ptr[ADDR_LEN-1:0]];
      end
    end

    assign bus.data_out   = dout_q;
    assign bus.data_valid = valid_q;
  end

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.level        = level;
  assign bus.almost_full  = (level >= AF_LVL);
  assign bus.almost_empty = (level <= AE_LVL);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule
